// File: rtl/flash_rd_pkg.sv
// Shared types and constants for the flash burst reader.
package flash_rd_pkg;

    localparam int DEFAULT_ADDR_W = 17;
    localparam int DEFAULT_DATA_W = 32;
    localparam int BURST_W        = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Size of the next burst: the smaller of the words still to issue and the burst limit.
    function automatic logic [BURST_W-1:0] burst_size(input logic [15:0] rem, input int unsigned lim);
        if (rem < 16'(lim))
            return rem[BURST_W-1:0];
        else
            return lim[BURST_W-1:0];
    endfunction

endpackage

// File: rtl/flash_rd_fifo.sv
// Show-ahead FIFO carrying a data word plus an end-of-command tag.
module flash_rd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  free_cnt
);

    logic [DATA_W:0]    mem [DEPTH];
    logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count;
    logic [DATA_W:0]    head_entry;
    logic               pop_ok;

    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
        free_cnt   = CNT_W'(DEPTH) - count;
        pop_ok     = pop && !empty;
        wr_ptr_d   = wr_ptr_q + CNT_W'(push);
        rd_ptr_d   = rd_ptr_q + CNT_W'(pop_ok);
        head_entry = mem[rd_ptr_q[AW-1:0]];
        // Masked while empty so stale RAM contents never reach the stream.
        head_data  = empty ? '0 : head_entry[DATA_W-1:0];
        head_last  = empty ? 1'b0 : head_entry[DATA_W];
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_q[AW-1:0]] <= {push_last, push_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/flash_burst_reader.sv
// Avalon-MM burst read master for the flash data port, buffering words into a stream FIFO.
// Defining FLASH_RD_SUM_EN adds a 32-bit running sum of the words received per command.
module flash_burst_reader
    import flash_rd_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [15:0]        cmd_len,
    output logic [ADDR_W-1:0]  avm_addr,
    output logic               avm_read,
    output logic [BURST_W-1:0] avm_burstcount,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_waitrequest,
    input  logic               avm_readdatavalid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               busy,
`ifdef FLASH_RD_SUM_EN
    output logic [31:0]        sum,
`endif
    output logic               done
);

    localparam int OCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int NEED_W = OCNT_W + 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [15:0]        rem_issue_q, rem_issue_d;
    logic [15:0]        rem_recv_q, rem_recv_d;
    logic [OCNT_W-1:0]  outstanding_q, outstanding_d;
    logic               ready_en_q, ready_en_d;
    logic               done_q, done_d;

    logic [BURST_W-1:0] bc;
    logic [OCNT_W-1:0]  free_cnt;
    logic [NEED_W-1:0]  need;
    logic               credit_ok, accept, beat, cmd_take;
    logic               fifo_empty, fifo_full;

    flash_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (beat),
        .push_data (avm_readdata),
        .push_last (rem_recv_q == 16'd1),
        .pop       (out_ready),
        .head_data (out_data),
        .head_last (out_last),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .free_cnt  (free_cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            rem_issue_q   <= '0;
            rem_recv_q    <= '0;
            outstanding_q <= '0;
            ready_en_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            rem_issue_q   <= rem_issue_d;
            rem_recv_q    <= rem_recv_d;
            outstanding_q <= outstanding_d;
            ready_en_q    <= ready_en_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_take) state_d = (cmd_len == 16'd0) ? DONE : ISSUE;
            ISSUE:   if (accept && rem_issue_q == 16'(bc)) state_d = DRAIN;
            DRAIN:   if (rem_recv_q == 16'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bc   = burst_size(rem_issue_q, BURST_LEN);
        // A burst goes out only if every word it returns is guaranteed a FIFO slot.
        need = {1'b0, outstanding_q} + NEED_W'(bc);
        credit_ok = ({1'b0, free_cnt} >= need);

        cmd_ready      = (state_q == IDLE) && ready_en_q;
        busy           = (state_q != IDLE);
        avm_read       = (state_q == ISSUE) && credit_ok;
        avm_burstcount = (state_q == ISSUE) ? bc : '0;
        avm_addr       = cur_addr_q;
        out_valid      = !fifo_empty;
        done           = done_q;
    end

    always_comb begin
        cmd_take = cmd_valid && cmd_ready;
        accept   = avm_read && !avm_waitrequest;
        beat     = avm_readdatavalid && (state_q == ISSUE || state_q == DRAIN);

        cur_addr_d    = cur_addr_q;
        rem_issue_d   = rem_issue_q;
        rem_recv_d    = rem_recv_q;
        outstanding_d = outstanding_q + (accept ? OCNT_W'(bc) : '0) - OCNT_W'(beat);
        ready_en_d    = 1'b1;
        done_d        = (state_q == DONE);

        if (cmd_take) begin
            cur_addr_d  = cmd_addr;
            rem_issue_d = cmd_len;
            rem_recv_d  = cmd_len;
        end else begin
            if (accept) begin
                cur_addr_d  = cur_addr_q + ADDR_W'(bc);
                rem_issue_d = rem_issue_q - 16'(bc);
            end
            if (beat)
                rem_recv_d = rem_recv_q - 16'd1;
        end
    end

`ifdef FLASH_RD_SUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (cmd_take)
            sum_d = '0;
        else if (beat)
            sum_d = sum_q + 32'(avm_readdata);
        sum = sum_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
